// File: rtl/alu_feeder_pkg.sv
// rtl/alu_feeder_pkg.sv - shared types and widths for the ALU command feeder
package alu_feeder_pkg;

  localparam int CHOICE_W = 3;
  localparam int CMD_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_HOLD
  } state_t;

  // Command word layout as stored in the FIFO: {a, b, choice}
  typedef struct packed {
    logic                a;
    logic                b;
    logic [CHOICE_W-1:0] choice;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO, power-of-two depth
module alu_cmd_fifo
  import alu_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; push+pop keeps count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_feeder.sv
// rtl/alu_cmd_feeder.sv - buffers ALU commands and sequences them to an external ALU
module alu_cmd_feeder
  import alu_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_a,
  input  logic                in_b,
  input  logic [CHOICE_W-1:0] in_choice,
  output logic                alu_a,
  output logic                alu_b,
  output logic [CHOICE_W-1:0] alu_choice,
  input  logic                alu_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_out,
  output logic [CHOICE_W-1:0] res_choice,
  output logic [SEQW-1:0]     res_tag
);

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CMD_W-1:0] w_head_word;
  cmd_t             w_head;

  state_t              r_state;
  logic                r_alu_a;
  logic                r_alu_b;
  logic [CHOICE_W-1:0] r_alu_choice;
  logic                r_res_valid;
  logic                r_res_out;
  logic [CHOICE_W-1:0] r_res_choice;
  logic [SEQW-1:0]     r_res_tag;
  logic [SEQW-1:0]     r_issue;

  // in_ready looks only at the registered full flag, never at a same-cycle pop
  assign in_ready    = !w_full;
  assign w_push      = in_valid && !w_full;
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && res_ready));
  assign w_head      = cmd_t'(w_head_word);

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_choice = r_alu_choice;
  assign res_valid  = r_res_valid;
  assign res_out    = r_res_out;
  assign res_choice = r_res_choice;
  assign res_tag    = r_res_tag;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_data({in_a, in_b, in_choice}),
    .pop      (w_pop),
    .pop_data (w_head_word),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Issue FSM: IDLE pops a command, DRIVE lets the ALU settle and captures, HOLD waits for the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_alu_a      <= 1'b0;
      r_alu_b      <= 1'b0;
      r_alu_choice <= '0;
      r_res_valid  <= 1'b0;
      r_res_out    <= 1'b0;
      r_res_choice <= '0;
      r_res_tag    <= '0;
      r_issue      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_alu_a      <= w_head.a;
            r_alu_b      <= w_head.b;
            r_alu_choice <= w_head.choice;
            r_state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_res_out    <= alu_out;
          r_res_choice <= r_alu_choice;
          r_res_tag    <= r_issue;
          r_res_valid  <= 1'b1;
          r_issue      <= r_issue + SEQW'(1);
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_alu_a      <= w_head.a;
              r_alu_b      <= w_head.b;
              r_alu_choice <= w_head.choice;
              r_state      <= ST_DRIVE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_feeder.md
ALU_CMD_FEEDER -- requirements
Module: alu_cmd_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter SEQW, default 8: result sequence-tag width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1: command offered.
REQ-006 SHALL have port in_ready  output  1: command accepted when in_valid && in_ready at the clock edge.
REQ-007 SHALL have ports in_a and in_b  input  1 each: command operands.
REQ-008 SHALL have port in_choice  input  3: command operation select.
REQ-009 SHALL have ports alu_a and alu_b  output  1 each: registered operands driven to the downstream ALU.
REQ-010 SHALL have port alu_choice  output  3: registered operation select driven to the ALU.
REQ-011 SHALL have port alu_out  input  1: combinational ALU result.
REQ-012 SHALL have port res_valid  output  1: result available.
REQ-013 SHALL have port res_ready  input  1: result consumed when res_valid && res_ready at the clock edge.
REQ-014 SHALL have port res_out  output  1: captured ALU result.
REQ-015 SHALL have port res_choice  output  3: choice that produced res_out.
REQ-016 SHALL have port res_tag  output  SEQW: issue sequence number of this result.

Function
REQ-017 SHALL buffer accepted commands {a,b,choice} in FIFO order, DEPTH entries.
REQ-018 SHALL drive in_ready = !full, independent of any same-cycle pop; a push while full SHALL NOT occur.
REQ-019 SHALL implement FSM states IDLE, DRIVE, HOLD.
REQ-020 IDLE: if FIFO non-empty at the edge, pop head, load alu_a/alu_b/alu_choice, go DRIVE; else stay.
REQ-021 DRIVE: capture alu_out into res_out and alu_choice into res_choice, load res_tag from issue counter, set res_valid=1, increment counter, go HOLD.
REQ-022 HOLD: hold res_* and alu_* stable while res_valid && !res_ready.
REQ-023 HOLD with res_ready=1: clear res_valid; if FIFO non-empty, pop and load next command, go DRIVE; else go IDLE.
REQ-024 Latency: command pushed into empty FIFO while IDLE -> alu_* updated 1 cycle after acceptance, res_valid high 2 cycles after acceptance.
REQ-025 Throughput: at most one result per 2 cycles with res_ready held high.
REQ-026 Push to empty FIFO SHALL NOT be visible to IDLE in the same cycle (no bypass).
REQ-027 Simultaneous push and pop with FIFO not full SHALL leave occupancy unchanged and preserve order.
REQ-028 Issue counter SHALL wrap modulo 2^SEQW (2^SEQW-1 -> 0) with no stall.
REQ-029 alu_* SHALL retain the last issued command in IDLE.

Reset
REQ-030 On rst=1 at an edge: FIFO pointers and occupancy 0, state IDLE, issue counter 0.
REQ-031 On reset: in_ready=1, alu_a=0, alu_b=0, alu_choice=0, res_valid=0, res_out=0, res_choice=0, res_tag=0.
REQ-032 Reset mid-operation SHALL discard all buffered and in-flight commands; no result for them SHALL appear.
REQ-033 Commands offered during the reset cycle SHALL NOT be accepted.

Structure
REQ-034 Shared package alu_feeder_pkg SHALL hold the FSM state enum, CHOICE_W=3, and CMD_W=5 command-word width.
REQ-035 FIFO SHALL be sub-module alu_cmd_fifo (sync FIFO with push, pop, full, empty, parameter DEPTH).
REQ-036 alu_cmd_feeder SHALL NOT instantiate the ALU; ALU connects externally.

Verification (bench stub: alu_out = alu_a ^ alu_b unless the real ALU is connected)
REQ-037 Single command a=1,b=0,choice=5, res_ready=1 -> alu_* update 1 cycle after acceptance; res_valid 2 cycles after acceptance with res_out=1, res_choice=5, res_tag=0.
REQ-038 Fill: res_ready=0, offer 5 commands back-to-back -> in_ready low after 4 accepted while 1 is held in HOLD; first result held stable; releasing res_ready drains in order with tags 0..4.
REQ-039 Backpressure: res_ready toggles 0/1 every cycle over 32 random commands -> results match scoreboard in order, none lost or duplicated.
REQ-040 Wrap: 260 commands with SEQW=8 -> tags run 255 then 0, 1, 2, 3.
REQ-041 Reset mid-operation: rst=1 for 1 cycle with 3 buffered commands and res_valid=1 -> next cycle res_valid=0, in_ready=1, res_tag=0; no stale result appears afterward.
REQ-042 Simultaneous push/pop with 2 entries -> occupancy stays 2, order preserved.
